// File: rtl/hcf_pkg.sv
// -----------------------------------------------------------------------------
// hcf_pkg
// Shared definitions for the HCF requester and its watchdog: the requester
// state encoding and the default operand width / watchdog limit.
// -----------------------------------------------------------------------------
package hcf_pkg;

   // Default operand / result width in bits.
   localparam int HCF_N_DEFAULT       = 8;

   // Default number of WAIT cycles before an operation is abandoned.
   localparam int HCF_TIMEOUT_DEFAULT = 1024;

   // Requester states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } hcf_state_e;

endpackage

// File: rtl/hcf_watchdog.sv
// -----------------------------------------------------------------------------
// hcf_watchdog
// Clear/enable up-counter with a terminal-count flag. Intended for any
// requester that has to bound how long it waits on a multi-cycle engine.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   i_clr  in   restart the count at zero (has priority over i_en)
//   i_en   in   count one cycle
//   o_tc   out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module hcf_watchdog
   import hcf_pkg::*;
#(
   parameter int TIMEOUT = HCF_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] ONE    = TW'(1);

   logic [TW-1:0] r_count;

   // Cycle counter; holds at the terminal count so it can never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != TC_VAL)) begin
         r_count <= r_count + ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/hcf_requester.sv
// -----------------------------------------------------------------------------
// hcf_requester
// Initiator side of the HCF engine handshake. Takes operand pairs from a
// valid/ready request stream, pulses hcf_start to the engine, waits for
// hcf_done under a watchdog and returns the result on a valid/ready response
// stream. A pair with a zero operand is answered directly (gcd(x,0)=x).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   s_valid/s_ready      request handshake (s_ready = idle)
//   s_a, s_b             operand pair
//   m_valid/m_ready      response handshake
//   m_hcf, m_err         result; m_err=1 means the watchdog expired (m_hcf=0)
//   hcf_start            one-cycle start pulse to the engine
//   hcf_in1, hcf_in2     operands to the engine, stable through ISSUE and WAIT
//   hcf_done, hcf_result engine completion (pulse or level) and its result
//   busy                 requester is not idle
// -----------------------------------------------------------------------------
module hcf_requester
   import hcf_pkg::*;
#(
   parameter int N       = HCF_N_DEFAULT,
   parameter int TIMEOUT = HCF_TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [N-1:0] s_a,
   input  logic [N-1:0] s_b,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [N-1:0] m_hcf,
   output logic         m_err,
   output logic         hcf_start,
   output logic [N-1:0] hcf_in1,
   output logic [N-1:0] hcf_in2,
   input  logic         hcf_done,
   input  logic [N-1:0] hcf_result,
   output logic         busy
);

   hcf_state_e   r_state;
   logic         r_arm;
   logic         r_start;
   logic [N-1:0] r_in1;
   logic [N-1:0] r_in2;
   logic         r_m_valid;
   logic [N-1:0] r_m_hcf;
   logic         r_m_err;

   logic         w_bypass;
   logic         w_tc;
   logic         w_wd_clr;
   logic         w_wd_en;

   // Either operand zero: the answer is the other operand, no engine needed.
   assign w_bypass = (s_a == '0) || (s_b == '0);

   assign w_wd_clr = (r_state == ST_ISSUE);
   assign w_wd_en  = (r_state == ST_WAIT);

   hcf_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_wd_clr),
      .i_en  (w_wd_en),
      .o_tc  (w_tc)
   );

   // Request/response sequencing and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_arm     <= 1'b0;
         r_start   <= 1'b0;
         r_in1     <= '0;
         r_in2     <= '0;
         r_m_valid <= 1'b0;
         r_m_hcf   <= '0;
         r_m_err   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (s_valid) begin
                  if (w_bypass) begin
                     r_m_hcf   <= s_a | s_b;
                     r_m_err   <= 1'b0;
                     r_m_valid <= 1'b1;
                     r_state   <= ST_RESP;
                  end else begin
                     // Operands and start are registered together so the
                     // engine sees stable inputs for the whole start cycle.
                     r_in1   <= s_a;
                     r_in2   <= s_b;
                     r_start <= 1'b1;
                     r_state <= ST_ISSUE;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               r_arm   <= 1'b0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done is only trusted after it has been seen low once in
               // this WAIT, so a level left high by the last operation (or
               // by an engine still finishing an aborted one) is ignored.
               if (!hcf_done) begin
                  r_arm <= 1'b1;
               end else begin
                  r_arm <= r_arm;
               end
               if (r_arm && hcf_done) begin
                  r_m_hcf   <= hcf_result;
                  r_m_err   <= 1'b0;
                  r_m_valid <= 1'b1;
                  r_state   <= ST_RESP;
               end else if (w_tc) begin
                  r_m_hcf   <= '0;
                  r_m_err   <= 1'b1;
                  r_m_valid <= 1'b1;
                  r_state   <= ST_RESP;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_RESP: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_state <= ST_RESP;
               end
            end
            default: begin
               r_m_valid <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_ready   = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign m_valid   = r_m_valid;
   assign m_hcf     = r_m_hcf;
   assign m_err     = r_m_err;
   assign hcf_start = r_start;
   assign hcf_in1   = r_in1;
   assign hcf_in2   = r_in2;

endmodule

// File: tb/tb_hcf_requester.sv
// -----------------------------------------------------------------------------
// tb_hcf_requester
// Directed bench for hcf_requester (N=8, TIMEOUT=16) with a behavioural HCF
// engine (pulse, level or dead) and a queue-based response scoreboard.
// -----------------------------------------------------------------------------
module tb_hcf_requester;

   localparam int N  = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid;
   logic         s_ready;
   logic [N-1:0] s_a;
   logic [N-1:0] s_b;
   logic         m_valid;
   logic         m_ready;
   logic [N-1:0] m_hcf;
   logic         m_err;
   logic         hcf_start;
   logic [N-1:0] hcf_in1;
   logic [N-1:0] hcf_in2;
   logic         hcf_done;
   logic [N-1:0] hcf_result;
   logic         busy;

   // 10-unit clock.
   always #5 clk = ~clk;

   hcf_requester #(.N(N), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_a        (s_a),
      .s_b        (s_b),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_hcf      (m_hcf),
      .m_err      (m_err),
      .hcf_start  (hcf_start),
      .hcf_in1    (hcf_in1),
      .hcf_in2    (hcf_in2),
      .hcf_done   (hcf_done),
      .hcf_result (hcf_result),
      .busy       (busy)
   );

   typedef struct {
      logic [N-1:0] hcf;
      logic         err;
      int           lat;
   } exp_t;

   exp_t         sb_q[$];
   int           checks    = 0;
   int           passes    = 0;
   int           cyc       = 0;
   int           acc_cyc   = 0;
   bit           in_op     = 1'b0;
   bit           eng_op    = 1'b0;
   logic [N-1:0] cur_a     = '0;
   logic [N-1:0] cur_b     = '0;
   logic [N-1:0] st_in1    = '0;
   logic [N-1:0] st_in2    = '0;
   int           start_cnt = 0;
   int           hs_bad    = 0;
   int           in_bad    = 0;
   int           lat_seen  = 0;
   logic         mv_prev   = 1'b0;
   int           eng_mode  = 0;   // 0 pulse done, 1 level done, 2 never done
   int           eng_cnt   = 0;
   logic [N-1:0] eng_pend  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] gcd_f(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic [N-1:0] t;
      x = a;
      y = b;
      while (y != '0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Cycle counter for latency measurement.
   always @(posedge clk) cyc++;

   // Behavioural HCF engine: done three negedges after start is seen.
   always @(negedge clk) begin
      if (hcf_start === 1'b1 && eng_mode != 2) begin
         eng_cnt  = 3;
         eng_pend = gcd_f(hcf_in1, hcf_in2);
         if (eng_mode == 0) hcf_done = 1'b0;
      end else if (eng_cnt > 0) begin
         eng_cnt = eng_cnt - 1;
         if (eng_cnt == 0) begin
            hcf_done   = 1'b1;
            hcf_result = eng_pend;
         end else if (eng_cnt == 1 || eng_mode == 0) begin
            hcf_done = 1'b0;   // level mode keeps the stale done one WAIT cycle
         end
      end else if (eng_mode != 1) begin
         hcf_done = 1'b0;
      end
   end

   // Monitor: start/operand tracking, handshake invariants, scoreboard pops.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst !== 1'b1) begin
         if (hcf_start === 1'b1) begin
            start_cnt++;
            st_in1 = hcf_in1;
            st_in2 = hcf_in2;
            eng_op = 1'b1;
            chk("start_in1", hcf_in1, cur_a);
            chk("start_in2", hcf_in2, cur_b);
         end else if (eng_op && m_valid !== 1'b1 &&
                      (hcf_in1 !== st_in1 || hcf_in2 !== st_in2)) begin
            in_bad++;
         end
         if (in_op && (s_ready !== 1'b0 || busy !== 1'b1)) hs_bad++;
         if (m_valid === 1'b1 && mv_prev !== 1'b1) lat_seen = cyc + 1 - acc_cyc;
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               chk("resp_hcf", m_hcf, e.hcf);
               chk("resp_err", m_err, e.err);
               chk("resp_latency", lat_seen, e.lat);
            end
            in_op  = 1'b0;
            eng_op = 1'b0;
         end
         mv_prev = m_valid;
      end
   end

   // Issue one request (called at a negedge); returns at the negedge after accept.
   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eh, input logic ee, input int el);
      int t;
      t = 0;
      while (s_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("s_ready_wait", s_ready, 1);
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      cur_a   = a;
      cur_b   = b;
      sb_q.push_back('{hcf: eh, err: ee, lat: el});
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      in_op   = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Wait (bounded) until the outstanding response has been taken.
   task automatic wait_idle();
      int t;
      t = 0;
      while (in_op && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("resp_wait", in_op, 0);
   endtask

   // Hard stop if the run ever stalls.
   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "simulation time limit reached");
   end

   // Directed stimulus.
   initial begin
      int s0;
      int mv_cnt;
      rst        = 1'b1;
      s_valid    = 1'b0;
      s_a        = '0;
      s_b        = '0;
      m_ready    = 1'b1;
      hcf_done   = 1'b0;
      hcf_result = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_hcf", m_hcf, 0);
      chk("rst_m_err", m_err, 0);
      chk("rst_hcf_start", hcf_start, 0);
      chk("rst_hcf_in1", hcf_in1, 0);
      chk("rst_hcf_in2", hcf_in2, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 1);

      // 1: single operation
      s0 = start_cnt;
      send(8'd24, 8'd18, 8'd6, 1'b0, 5);
      wait_idle();
      chk("t1_starts", start_cnt - s0, 1);

      // 2: back-to-back
      s0 = start_cnt;
      send(8'd15, 8'd25, 8'd5, 1'b0, 5);
      send(8'd100, 8'd10, 8'd10, 1'b0, 5);
      wait_idle();
      chk("t2_starts", start_cnt - s0, 2);

      // 3: zero-operand bypass
      s0 = start_cnt;
      send(8'd0, 8'd9, 8'd9, 1'b0, 1);
      send(8'd0, 8'd0, 8'd0, 1'b0, 1);
      wait_idle();
      chk("t3_starts", start_cnt - s0, 0);

      // 4: backpressure
      m_ready = 1'b0;
      send(8'd24, 8'd18, 8'd6, 1'b0, 5);
      for (int i = 0; i < 20 && m_valid !== 1'b1; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_m_valid", m_valid, 1);
         chk("bp_m_hcf", m_hcf, 6);
         chk("bp_m_err", m_err, 0);
         chk("bp_s_ready", s_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_released", m_valid, 0);
      wait_idle();

      // 5: dead engine then recovery
      eng_mode = 2;
      send(8'd24, 8'd18, 8'd0, 1'b1, TO + 2);
      wait_idle();
      eng_mode = 0;
      send(8'd24, 8'd18, 8'd6, 1'b0, 5);
      wait_idle();

      // 6: reset during WAIT, late done ignored
      send(8'd24, 8'd18, 8'd6, 1'b0, 5);
      @(negedge clk);
      chk("t6_busy_in_wait", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb_q.delete();
      in_op  = 1'b0;
      eng_op = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_m_valid", m_valid, 0);
      chk("t6_m_hcf", m_hcf, 0);
      chk("t6_m_err", m_err, 0);
      chk("t6_hcf_start", hcf_start, 0);
      chk("t6_hcf_in1", hcf_in1, 0);
      chk("t6_hcf_in2", hcf_in2, 0);
      chk("t6_busy", busy, 0);
      chk("t6_s_ready", s_ready, 1);
      mv_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_valid !== 1'b0) mv_cnt++;
      end
      chk("t6_late_done_ignored", mv_cnt, 0);
      send(8'd100, 8'd10, 8'd10, 1'b0, 5);
      wait_idle();

      // 7: level-done engine; stale done from the first op must not be taken
      eng_mode = 1;
      send(8'd100, 8'd10, 8'd10, 1'b0, 5);
      wait_idle();
      send(8'd15, 8'd25, 8'd5, 1'b0, 5);
      wait_idle();
      eng_mode = 0;
      repeat (3) @(negedge clk);

      chk("sb_empty", sb_q.size(), 0);
      chk("in_hold_violations", in_bad, 0);
      chk("sready_busy_violations", hs_bad, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hcf_requester.md
Name: hcf_requester

Overview:
Initiator side of the HCF engine handshake (start / in1 / in2 / done / hcf). It accepts operand pairs on a valid/ready request stream and pulses start to the HCF engine. It then waits for done, with a watchdog, and returns the result on a valid/ready response stream. Zero operands bypass the engine.

Parameters:
N, 8, operand/result width in bits
TIMEOUT, 1024, max cycles in WAIT before an operation is abandoned (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_valid  input  1  request operand pair valid
s_ready  output  1  requester can accept a pair
s_a  input  N  operand A
s_b  input  N  operand B
m_valid  output  1  response valid
m_ready  input  1  downstream accepts response
m_hcf  output  N  result
m_err  output  1  1 = watchdog timeout, m_hcf forced 0
hcf_start  output  1  one-cycle start pulse to engine
hcf_in1  output  N  operand A to engine, held stable from ISSUE through WAIT
hcf_in2  output  N  operand B to engine, held stable from ISSUE through WAIT
hcf_done  input  1  engine done (pulse or level, both supported)
hcf_result  input  N  engine result, valid while hcf_done=1
busy  output  1  high in any state except IDLE

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. Every register clears on the first rising edge with rst=1.
- Reset state:
  - state=IDLE.
  - m_valid, m_hcf, m_err, hcf_start, hcf_in1, hcf_in2 all 0; busy=0.
  - s_ready=1 once rst deasserts.
- States IDLE, ISSUE, WAIT, RESP. s_ready = (state==IDLE), combinational.
- IDLE: on s_valid&s_ready, register a=s_a and b=s_b.
  - If a==0 or b==0: m_hcf=a|b (gcd(0,0)=0), m_err=0, go to RESP. The engine is not touched.
  - Otherwise go to ISSUE.
- ISSUE: hcf_start=1 for exactly this cycle; hcf_in1=a, hcf_in2=b; clear timer and arm flag; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - arm is set on any cycle where hcf_done=0. This ignores a stale level-done left over from the previous operation.
  - If arm=1 and hcf_done=1: capture m_hcf=hcf_result, m_err=0, go to RESP.
  - Else, if timer reaches TIMEOUT-1: m_hcf=0, m_err=1, go to RESP.
  - Done wins over timeout in the same cycle.
- RESP: m_valid=1. m_hcf and m_err are held stable until m_valid&m_ready; then go to IDLE and m_valid drops the next cycle. No new request is accepted while in RESP.
- Latency, with the accept edge as cycle 0:
  - Bypass: m_valid=1 at cycle 1.
  - Normal: hcf_start at cycle 1; m_valid one cycle after the armed done is sampled.
  - Maximum: TIMEOUT+2 cycles to m_valid.
- hcf_done in IDLE, ISSUE or RESP is ignored.
- Reset mid-operation returns to IDLE with all outputs cleared. A done arriving later from the still-running engine is ignored: it lands in IDLE, or in a fresh WAIT before arm is set.
- Throughput: at most one operation in flight. A back-to-back request is accepted in the cycle after the response handshake.
- Timer width is $clog2(TIMEOUT+1) bits; the timer saturates and never wraps.

Decomposition:
- Package hcf_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the default N;
  - the default TIMEOUT.
- Natural sub-module: hcf_watchdog. It is a clear/enable counter with a terminal-count output parameterised by TIMEOUT, and is reusable by other multi-cycle-engine requesters.

Test Plan:
1. Request (24,18) with the real HCF engine -> one hcf_start pulse, hcf_in1=24 and hcf_in2=18 held; response m_hcf=6, m_err=0.
2. Back-to-back requests (15,25) then (100,10), m_ready=1 -> responses 5 then 10 in order. s_ready=0 throughout each operation; exactly two hcf_start pulses.
3. Request (0,9), then (0,0) -> m_hcf=9, then 0, each with m_valid one cycle after accept. hcf_start never asserts.
4. Backpressure: (24,18) with m_ready=0 for 5 cycles after m_valid -> m_valid, m_hcf=6 and m_err=0 held stable; s_ready=0; handshake completes on the first m_ready=1 cycle.
5. Engine model that never asserts done, TIMEOUT=16 -> m_valid exactly 18 cycles after accept, m_hcf=0, m_err=1. The next request (24,18) with a working model returns 6.
6. Reset for 1 cycle while in WAIT -> all outputs 0 the next cycle. A late hcf_done pulse is ignored (no m_valid). A following request (100,10) returns 10.
